// File: rtl/cpu_pkg.sv
// Shared constants and sweep FSM state type for the reg_bank8 register bank.
package cpu_pkg;
  localparam int WIDTH      = 32;
  localparam int NREGS      = 8;
  localparam int REG_ADDR_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_t;
endpackage

// File: rtl/reg_bank8_sweep.sv
// Clear-sweep controller: walks a 3-bit index over every register, one per cycle,
// holding busy high for exactly NREGS cycles after a clr_req seen in IDLE.
module reg_bank8_sweep
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  clr_en,
  output logic [REG_ADDR_W-1:0] clr_idx,
  output logic                  busy
);

  sweep_state_t          state;
  sweep_state_t          state_nxt;
  logic [REG_ADDR_W-1:0] idx;
  logic [REG_ADDR_W-1:0] idx_nxt;

  // State and index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= {REG_ADDR_W{1'b0}};
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic; the index wraps naturally to 0 after the last register.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = SWEEP;
          idx_nxt   = {REG_ADDR_W{1'b0}};
        end else begin
          state_nxt = IDLE;
        end
      end
      SWEEP: begin
        idx_nxt = idx + REG_ADDR_W'(1);
        if (idx == REG_ADDR_W'(NREGS - 1)) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = SWEEP;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = {REG_ADDR_W{1'b0}};
      end
    endcase
  end

  assign busy    = (state == SWEEP);
  assign clr_en  = busy;
  assign clr_idx = idx;

endmodule

// File: rtl/reg_bank8.sv
// 8 x WIDTH register bank with valid/ready write port and clear sweep, feeding mux8 in0..in7.
// Optional zero-latency write forwarding is enabled by defining REG_BANK_BYPASS_EN.
module reg_bank8
  import cpu_pkg::REG_ADDR_W, cpu_pkg::NREGS;
#(
  parameter int WIDTH   = cpu_pkg::WIDTH,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  clr_req,
  output logic                  busy,
  output logic [NREGS-1:0]      valid,
  output logic [WIDTH-1:0]      out0,
  output logic [WIDTH-1:0]      out1,
  output logic [WIDTH-1:0]      out2,
  output logic [WIDTH-1:0]      out3,
  output logic [WIDTH-1:0]      out4,
  output logic [WIDTH-1:0]      out5,
  output logic [WIDTH-1:0]      out6,
  output logic [WIDTH-1:0]      out7
);

  logic [WIDTH-1:0]      regs [NREGS];
  logic [WIDTH-1:0]      rd   [NREGS];
  logic                  up;
  logic                  wr_fire;
  logic                  wr_keep;
  logic                  clr_en;
  logic [REG_ADDR_W-1:0] clr_idx;

  reg_bank8_sweep u_sweep (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .clr_en  (clr_en),
    .clr_idx (clr_idx),
    .busy    (busy)
  );

  // up stays low through reset so wr_ready only rises on the first clock after release.
  assign wr_ready = up & ~busy;
  assign wr_fire  = wr_valid & wr_ready;
  assign wr_keep  = wr_fire & ~(R0_ZERO && (wr_addr == {REG_ADDR_W{1'b0}}));

  // Register array, valid mask and ready enable; writes never coincide with a sweep clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up    <= 1'b0;
      valid <= {NREGS{1'b0}};
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= {WIDTH{1'b0}};
      end
    end else begin
      up <= 1'b1;
      if (wr_keep) begin
        regs[wr_addr]  <= wr_data;
        valid[wr_addr] <= 1'b1;
      end
      if (clr_en) begin
        regs[clr_idx]  <= {WIDTH{1'b0}};
        valid[clr_idx] <= 1'b0;
      end
    end
  end

  // Read path: register contents, optionally overridden by the write being accepted now.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      rd[i] = regs[i];
`ifdef REG_BANK_BYPASS_EN
      if (wr_keep && (wr_addr == REG_ADDR_W'(i))) begin
        rd[i] = wr_data;
      end else begin
        rd[i] = regs[i];
      end
`endif
    end
  end

  assign out0 = rd[0];
  assign out1 = rd[1];
  assign out2 = rd[2];
  assign out3 = rd[3];
  assign out4 = rd[4];
  assign out5 = rd[5];
  assign out6 = rd[6];
  assign out7 = rd[7];

endmodule

// File: tb/tb_reg_bank8.sv
// Self-checking bench for reg_bank8: per-cycle comparison against a behavioural model
// plus directed checks with hand-computed values.
module tb_reg_bank8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_addr = 3'd0;
  logic [31:0] wr_data = 32'h0;
  logic        clr_req = 1'b0;
  logic        busy;
  logic [7:0]  valid;
  logic [31:0] outs [8];

  int pass_cnt  = 0;
  int total_cnt = 0;

  reg_bank8 dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .busy     (busy),
    .valid    (valid),
    .out0     (outs[0]),
    .out1     (outs[1]),
    .out2     (outs[2]),
    .out3     (outs[3]),
    .out4     (outs[4]),
    .out5     (outs[5]),
    .out6     (outs[6]),
    .out7     (outs[7])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: sweep as a countdown of remaining registers.
  logic [31:0] m_reg [8];
  logic [7:0]  m_valid = 8'h00;
  int          sweep_left = 0;
  bit          m_up = 1'b0;

  initial for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_reg[i] <= 32'h0;
      m_valid    <= 8'h00;
      sweep_left <= 0;
      m_up       <= 1'b0;
    end else begin
      m_up <= 1'b1;
      if (sweep_left != 0) begin
        m_reg[8 - sweep_left]   <= 32'h0;
        m_valid[8 - sweep_left] <= 1'b0;
        sweep_left              <= sweep_left - 1;
      end else begin
        if (clr_req) sweep_left <= 8;
        if (wr_valid && m_up && wr_addr != 3'd0) begin
          m_reg[wr_addr]   <= wr_data;
          m_valid[wr_addr] <= 1'b1;
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    logic        e_ready;
    logic [31:0] e_out;
    if ($time > 2) begin
      e_ready = !rst && m_up && (sweep_left == 0);
      chk("model_wr_ready", {31'h0, wr_ready}, {31'h0, e_ready});
      chk("model_busy", {31'h0, busy}, {31'h0, sweep_left != 0});
      chk("model_valid", {24'h0, valid}, {24'h0, m_valid});
      for (int i = 0; i < 8; i++) begin
        e_out = m_reg[i];
`ifdef REG_BANK_BYPASS_EN
        if (e_ready && wr_valid && wr_addr == 3'(i) && i != 0) e_out = wr_data;
`endif
        chk($sformatf("model_out%0d", i), outs[i], e_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (!wr_ready && n < 40) begin
      tick();
      n++;
    end
    chk("write_accept_bound", {31'h0, n < 40}, 32'h1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk(name, {31'h0, n < 40}, 32'h1);
  endtask

  initial begin
    logic [3:0]  nib;
    logic [31:0] d;
    int          bcnt;

    // Reset held 3 cycles
    #1 rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 8; i++) chk($sformatf("rst_out%0d", i), outs[i], 32'h0);
    chk("rst_valid", {24'h0, valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ready", {31'h0, wr_ready}, 32'h0);
    rst = 1'b0;
    tick();
    chk("ready_after_release", {31'h0, wr_ready}, 32'h1);

    // Writes r1..r7
    for (int a = 1; a < 8; a++) begin
      nib = 4'(a);
      d   = {8{nib}};
      do_write(3'(a), d);
      chk($sformatf("wr_out%0d", a), outs[a], d);
    end
    chk("wr_valid_mask", {24'h0, valid}, 32'h0000_00FE);
    chk("wr_out4_literal", outs[4], 32'h4444_4444);

    // r0 hardwired zero
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 32'hFFFF_FFFF;
    chk("r0_ready", {31'h0, wr_ready}, 32'h1);
    tick();
    wr_valid = 1'b0;
    chk("r0_out", outs[0], 32'h0);
    chk("r0_valid", {24'h0, valid}, 32'h0000_00FE);
    chk("r0_ready_after", {31'h0, wr_ready}, 32'h1);

    // Clear sweep with a write held across it
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 32'hA5A5_A5A5;
    bcnt = 0;
    while (busy && bcnt < 20) begin
      chk("sweep_ready_low", {31'h0, wr_ready}, 32'h0);
      bcnt++;
      tick();
    end
    chk("sweep_busy_cycles", bcnt, 32'd8);
    chk("post_sweep_ready", {31'h0, wr_ready}, 32'h1);
    tick();
    wr_valid = 1'b0;
    chk("held_write_out3", outs[3], 32'hA5A5_A5A5);
    chk("held_write_valid", {24'h0, valid}, 32'h0000_0008);
    chk("held_write_out7", outs[7], 32'h0);

    // Collision: write and clr_req on the same edge
    wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 32'h5555_5555; clr_req = 1'b1;
    chk("coll_ready", {31'h0, wr_ready}, 32'h1);
    tick();
    wr_valid = 1'b0; clr_req = 1'b0;
    chk("coll_out5", outs[5], 32'h5555_5555);
    chk("coll_busy", {31'h0, busy}, 32'h1);
    wait_idle("coll_sweep_bound");
    chk("coll_out5_cleared", outs[5], 32'h0);
    chk("coll_valid_cleared", {24'h0, valid}, 32'h0);

    // Reset during sweep cycle 4
    do_write(3'd6, 32'h1234_5678);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (3) tick();
    chk("midsweep_pre_busy", {31'h0, busy}, 32'h1);
    chk("midsweep_pre_out6", outs[6], 32'h1234_5678);
    rst = 1'b1;
    #1;
    chk("midsweep_out6", outs[6], 32'h0);
    chk("midsweep_busy", {31'h0, busy}, 32'h0);
    chk("midsweep_valid", {24'h0, valid}, 32'h0);
    chk("midsweep_ready", {31'h0, wr_ready}, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Acceptance-cycle visibility of a write to r2
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 32'h3333_3333;
    #1;
`ifdef REG_BANK_BYPASS_EN
    chk("bypass_out2_same_cycle", outs[2], 32'h3333_3333);
`else
    chk("nobypass_out2_same_cycle", outs[2], 32'h0);
`endif
    tick();
    wr_valid = 1'b0;
    chk("r2_after_accept", outs[2], 32'h3333_3333);
    chk("r2_valid", {24'h0, valid}, 32'h0000_0004);

    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
